// File: rtl/gcd_pkg.sv
// Shared constants and types for the 4-bit GCD core and its memory responder.
// Port addresses, nibble/address types, core opcodes and responder states.
package gcd_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 4;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] nib_t;

    localparam addr_t IN_ADDR  = 8'd253;
    localparam addr_t OUT_ADDR = 8'd254;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LD   = 4'h1,
        OP_ST   = 4'h2,
        OP_SUB  = 4'h3,
        OP_JZ   = 4'h4,
        OP_JC   = 4'h5,
        OP_JMP  = 4'h6,
        OP_IN   = 4'h7,
        OP_OUT  = 4'h8,
        OP_HALT = 4'hF
    } gcd_op_t;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } resp_state_t;

    function automatic nib_t nib_add(input nib_t a, input nib_t b);
        return a + b;
    endfunction
endpackage

// File: rtl/gcd_mem_responder_if.sv
// Core-side fetch/load/store bus: one request per cycle, read data one cycle later.
// No backpressure: the responder accepts every request in RUN.
interface gcd_mem_responder_if;
    import gcd_pkg::*;

    logic  req;
    logic  we;
    addr_t addr;
    nib_t  wdata;
    nib_t  rdata;
    logic  rvalid;

    modport master (output req, output we, output addr, output wdata,
                    input  rdata, input rvalid);
    modport slave  (input  req, input  we, input  addr, input  wdata,
                    output rdata, output rvalid);
endinterface

// File: rtl/gcd_ram256x4.sv
// Single-port 256x4 synchronous RAM, write-first, registered read (latency 1).
// No backpressure; contents survive reset.
module gcd_ram256x4
    import gcd_pkg::*;
(
    input  logic  clk,
    input  logic  i_en,
    input  logic  i_we,
    input  addr_t i_addr,
    input  nib_t  i_wdata,
    output nib_t  o_rdata
);
    nib_t r_mem [0:(1<<ADDR_W)-1];
    nib_t r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
                r_rdata       <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/gcd_mem_responder.sv
// Program loader + memory/IO responder for the GCD core; reads return 1 cycle after req.
// Load stream is accepted whenever ld_ready (LOAD only); GCD_MEM_CHECKSUM_EN adds image checksum.
module gcd_mem_responder
    import gcd_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ld_valid,
    input  nib_t                ld_data,
    input  logic                ld_last,
    output logic                ld_ready,
    output logic                core_run,
    output logic                load_err,
    gcd_mem_responder_if.slave  bus,
    input  nib_t                in_data,
    output nib_t                out_data,
    output logic                out_stb
);
    resp_state_t r_state;
    resp_state_t w_state_nxt;

    logic  r_ld_ready;
    addr_t r_ld_ptr;
    logic  r_rvalid;
    logic  r_ram_rd;
    nib_t  r_rdata;
    nib_t  r_out_data;
    logic  r_out_stb;

    logic  w_ld_acc;
    logic  w_ld_final;
    logic  w_ld_store;
    logic  w_run;
    logic  w_rd_req;
    logic  w_wr_req;
    logic  w_out_wr;
    logic  w_ram_rd;
    logic  w_ram_en;
    logic  w_ram_we;
    addr_t w_ram_addr;
    nib_t  w_ram_wdata;
    nib_t  w_ram_rdata;

    assign w_ld_acc   = ld_valid && r_ld_ready;
    assign w_ld_final = w_ld_acc && (ld_last || (r_ld_ptr == '1));

`ifdef GCD_MEM_CHECKSUM_EN
    nib_t r_sum;
    logic w_cs_ok;

    // The tagged-last nibble is the checksum, never stored.
    assign w_ld_store = w_ld_acc && !ld_last;
    assign w_cs_ok    = (r_sum == ld_data);
`else
    assign w_ld_store = w_ld_acc;
`endif

    assign w_run    = (r_state == RUN);
    assign w_rd_req = w_run && bus.req && !bus.we;
    assign w_wr_req = w_run && bus.req && bus.we && (bus.addr != IN_ADDR);
    assign w_out_wr = w_wr_req && (bus.addr == OUT_ADDR);
    assign w_ram_rd = w_rd_req && (bus.addr != IN_ADDR) && (bus.addr != OUT_ADDR);

    always_comb begin
        w_state_nxt = r_state;
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = r_ld_ptr;
        w_ram_wdata = ld_data;

        case (r_state)
            LOAD: begin
                if (w_ld_final) begin
`ifdef GCD_MEM_CHECKSUM_EN
                    w_state_nxt = (ld_last && !w_cs_ok) ? ERR : RUN;
`else
                    w_state_nxt = RUN;
`endif
                end
            end
            RUN:     w_state_nxt = RUN;
            ERR:     w_state_nxt = ERR;
            default: w_state_nxt = LOAD;
        endcase

        if (w_ld_store) begin
            w_ram_en = 1'b1;
            w_ram_we = 1'b1;
        end else if (w_wr_req) begin
            w_ram_en    = 1'b1;
            w_ram_we    = 1'b1;
            w_ram_addr  = bus.addr;
            w_ram_wdata = bus.wdata;
        end else if (w_ram_rd) begin
            w_ram_en   = 1'b1;
            w_ram_addr = bus.addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ld_ready <= 1'b0;
            r_ld_ptr   <= '0;
            r_rvalid   <= 1'b0;
            r_ram_rd   <= 1'b0;
            r_rdata    <= '0;
            r_out_data <= '0;
            r_out_stb  <= 1'b0;
        end else begin
            r_ld_ready <= (w_state_nxt == LOAD);
            if (w_ld_acc && (r_ld_ptr != '1)) begin
                r_ld_ptr <= r_ld_ptr + 1'b1;
            end
            r_rvalid  <= w_rd_req;
            r_ram_rd  <= w_ram_rd;
            r_out_stb <= w_out_wr;
            if (w_out_wr) begin
                r_out_data <= bus.wdata;
            end
            // Port reads land here directly; RAM reads are captured a cycle
            // later so rdata holds even if a later write disturbs the RAM output.
            if (w_rd_req && (bus.addr == IN_ADDR)) begin
                r_rdata <= in_data;
            end else if (w_rd_req && (bus.addr == OUT_ADDR)) begin
                r_rdata <= r_out_data;
            end else if (r_ram_rd) begin
                r_rdata <= w_ram_rdata;
            end
        end
    end

`ifdef GCD_MEM_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (w_ld_store) begin
            r_sum <= nib_add(r_sum, ld_data);
        end
    end

    assign load_err = (r_state == ERR);
`else
    assign load_err = 1'b0;
`endif

    gcd_ram256x4 u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign ld_ready   = r_ld_ready;
    assign core_run   = w_run;
    assign bus.rdata  = r_ram_rd ? w_ram_rdata : r_rdata;
    assign bus.rvalid = r_rvalid;
    assign out_data   = r_out_data;
    assign out_stb    = r_out_stb;
endmodule

// File: tb/tb_gcd_mem_responder.sv
// Randomized bench for gcd_mem_responder against a behavioural memory/loader model.
// Also covers the GCD_MEM_CHECKSUM_EN build when that macro is defined.
module tb_gcd_mem_responder;
    import gcd_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ld_valid = 1'b0;
    logic [3:0] ld_data = '0;
    logic       ld_last = 1'b0;
    logic       ld_ready;
    logic       core_run;
    logic       load_err;
    logic [3:0] in_data = '0;
    logic [3:0] out_data;
    logic       out_stb;

    gcd_mem_responder_if bus();

    gcd_mem_responder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .core_run (core_run),
        .load_err (load_err),
        .bus      (bus),
        .in_data  (in_data),
        .out_data (out_data),
        .out_stb  (out_stb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model: mode 0 = loading, 1 = running, 2 = rejected image.
    int         m_mode = 0;
    int         m_ptr  = 0;
    logic [3:0] m_sum  = '0;
    logic [3:0] m_mem [256];
    logic [3:0] m_out  = '0;
    logic [3:0] m_rd   = '0;
    bit         m_rv   = 1'b0;
    bit         m_stb  = 1'b0;
    bit         m_ldr  = 1'b0;
    bit         m_acc  = 1'b0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        m_acc = 1'b0;
        if (!rst_n) begin
            m_mode = 0; m_ptr = 0; m_sum = '0; m_rd = '0;
            m_rv = 1'b0; m_out = '0; m_stb = 1'b0; m_ldr = 1'b0;
            return;
        end
        m_rv  = 1'b0;
        m_stb = 1'b0;
        if (m_mode == 0) begin
            if (ld_valid && m_ldr) begin
                m_acc = 1'b1;
`ifdef GCD_MEM_CHECKSUM_EN
                if (ld_last) begin
                    m_mode = (m_sum == ld_data) ? 1 : 2;
                end else begin
                    m_mem[m_ptr] = ld_data;
                    m_sum = m_sum + ld_data;
                    if (m_ptr == 255) m_mode = 1;
                    m_ptr++;
                end
`else
                m_mem[m_ptr] = ld_data;
                if (ld_last || m_ptr == 255) m_mode = 1;
                m_ptr++;
`endif
            end
        end else if (m_mode == 1 && bus.req) begin
            if (bus.we) begin
                if (bus.addr == OUT_ADDR) begin
                    m_out = bus.wdata;
                    m_stb = 1'b1;
                    m_mem[bus.addr] = bus.wdata;
                end else if (bus.addr != IN_ADDR) begin
                    m_mem[bus.addr] = bus.wdata;
                end
            end else begin
                m_rv = 1'b1;
                if (bus.addr == IN_ADDR)       m_rd = in_data;
                else if (bus.addr == OUT_ADDR) m_rd = m_out;
                else                           m_rd = m_mem[bus.addr];
            end
        end
        m_ldr = (m_mode == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ld_ready", {7'd0, ld_ready}, {7'd0, m_ldr});
            chk("core_run", {7'd0, core_run}, {7'd0, m_mode == 1});
            chk("load_err", {7'd0, load_err}, {7'd0, m_mode == 2});
            chk("rvalid",   {7'd0, bus.rvalid}, {7'd0, m_rv});
            chk("rdata",    {4'd0, bus.rdata}, {4'd0, m_rd});
            chk("out_data", {4'd0, out_data}, {4'd0, m_out});
            chk("out_stb",  {7'd0, out_stb}, {7'd0, m_stb});
        end
    end

    task automatic do_reset(input int n);
        rst_n = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; bus.req = 1'b0;
        repeat (n) tick();
        chk_en = 1'b1;
        rst_n = 1'b1;
    endtask

    task automatic load_nib(input logic [3:0] d, input bit last, input bit noisy);
        int budget = 40;
        if (noisy) repeat ($urandom_range(0, 2)) tick();
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        do begin
            bus.req = noisy && ($urandom_range(0, 1) == 1);
            bus.we = $urandom_range(0, 1) == 1;
            bus.addr = 8'($urandom_range(0, 255));
            bus.wdata = 4'($urandom_range(0, 15));
            tick();
            budget--;
        end while (!m_acc && budget > 0);
        if (!m_acc) begin
            errors++;
            $display("FAIL load_timeout actual=not_accepted expected=accepted");
        end
        ld_valid = 1'b0; ld_last = 1'b0; bus.req = 1'b0;
    endtask

    task automatic load_image(input logic [3:0] img[$]);
        logic [3:0] s = '0;
        foreach (img[i]) begin
`ifdef GCD_MEM_CHECKSUM_EN
            load_nib(img[i], 1'b0, 1'b0);
            s = s + img[i];
`else
            load_nib(img[i], i == img.size() - 1, 1'b0);
`endif
        end
`ifdef GCD_MEM_CHECKSUM_EN
        load_nib(s, 1'b1, 1'b0);
`endif
    endtask

    task automatic core_req(input bit w, input logic [7:0] a, input logic [3:0] d);
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
        tick();
        bus.req = 1'b0;
    endtask

    task automatic rand_traffic(input int n);
        for (int k = 0; k < n; k++) begin
            int sel = $urandom_range(0, 7);
            bus.req = $urandom_range(0, 3) != 0;
            bus.we = $urandom_range(0, 1) == 1;
            bus.wdata = 4'($urandom_range(0, 15));
            in_data = 4'($urandom_range(0, 15));
            if (sel == 0)      bus.addr = IN_ADDR;
            else if (sel == 1) bus.addr = OUT_ADDR;
            else if (sel == 2) bus.addr = 8'($urandom_range(0, 7));
            else               bus.addr = 8'($urandom_range(0, 255));
            tick();
        end
        bus.req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] img[$];
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;

        do_reset(2);
        chk("lit_rst_ldready", {7'd0, ld_ready}, 8'd0);
        tick();
        chk("lit_load_ldready", {7'd0, ld_ready}, 8'd1);

        // Full 256-nibble image without ld_last, stray requests during LOAD.
        for (int i = 0; i < 256; i++) begin
            logic [3:0] d;
            d = (i < 4) ? 4'(OP_IN + i) : 4'($urandom_range(0, 15));
            load_nib(d, 1'b0, 1'b1);
        end
        chk("lit_full_run", {7'd0, core_run}, 8'd1);
        chk("lit_full_ldready", {7'd0, ld_ready}, 8'd0);
        core_req(1'b0, 8'd0, 4'd0);
        chk("lit_full_rd0", {4'd0, bus.rdata}, {4'd0, 4'(OP_IN)});
        rand_traffic(400);

        do_reset(1);
        img = '{4'h6, 4'h7, 4'hF};
        load_image(img);
        chk("lit_run", {7'd0, core_run}, 8'd1);
        core_req(1'b0, 8'd0, 4'd0);
        chk("lit_rd0", {4'd0, bus.rdata}, 8'h6);
        chk("lit_rv0", {7'd0, bus.rvalid}, 8'd1);
        core_req(1'b0, 8'd1, 4'd0);
        chk("lit_rd1", {4'd0, bus.rdata}, 8'h7);
        core_req(1'b0, 8'd2, 4'd0);
        chk("lit_rd2", {4'd0, bus.rdata}, 8'hF);
        in_data = 4'h9;
        core_req(1'b0, IN_ADDR, 4'd0);
        chk("lit_in9", {4'd0, bus.rdata}, 8'h9);
        core_req(1'b1, IN_ADDR, 4'h4);
        chk("lit_wr_rv", {7'd0, bus.rvalid}, 8'd0);
        in_data = 4'h2;
        core_req(1'b0, IN_ADDR, 4'd0);
        chk("lit_in2", {4'd0, bus.rdata}, 8'h2);
        core_req(1'b1, OUT_ADDR, 4'hA);
        chk("lit_out", {4'd0, out_data}, 8'hA);
        chk("lit_stb", {7'd0, out_stb}, 8'd1);
        chk("lit_model_mem254", {4'd0, m_mem[254]}, 8'hA);
        core_req(1'b0, OUT_ADDR, 4'd0);
        chk("lit_stb_off", {7'd0, out_stb}, 8'd0);
        chk("lit_rd_out", {4'd0, bus.rdata}, 8'hA);
        core_req(1'b1, 8'd10, 4'h5);
        core_req(1'b0, 8'd10, 4'd0);
        chk("lit_raw", {4'd0, bus.rdata}, 8'h5);
        rand_traffic(300);

        do_reset(1);
        chk("lit_rst_run", {7'd0, core_run}, 8'd0);
        chk("lit_rst_out", {4'd0, out_data}, 8'd0);
        chk("lit_rst_rdata", {4'd0, bus.rdata}, 8'd0);
        rand_traffic(5);
        img = '{4'h1};
        load_image(img);
        chk("lit_reload_run", {7'd0, core_run}, 8'd1);
        core_req(1'b0, 8'd0, 4'd0);
        chk("lit_reload_rd0", {4'd0, bus.rdata}, 8'h1);
        rand_traffic(100);

`ifdef GCD_MEM_CHECKSUM_EN
        do_reset(1);
        load_nib(4'h3, 1'b0, 1'b0);
        load_nib(4'h5, 1'b0, 1'b0);
        load_nib(4'h8, 1'b1, 1'b0);
        chk("lit_cs_ok_run", {7'd0, core_run}, 8'd1);
        chk("lit_cs_ok_err", {7'd0, load_err}, 8'd0);
        do_reset(1);
        load_nib(4'h3, 1'b0, 1'b0);
        load_nib(4'h5, 1'b0, 1'b0);
        load_nib(4'h7, 1'b1, 1'b0);
        chk("lit_cs_bad_err", {7'd0, load_err}, 8'd1);
        chk("lit_cs_bad_run", {7'd0, core_run}, 8'd0);
        rand_traffic(30);
        chk("lit_cs_bad_ldready", {7'd0, ld_ready}, 8'd0);
`endif

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
